// File: rtl/multi_pulser.sv
// Multi-channel push-button pulser: per-channel synchroniser, debouncer, edge
// qualification and a small FSM that emits fixed-width pulses with optional auto-repeat.
module multi_pulser #(
  parameter int N_CH      = 4,
  parameter int DEB_CNT   = 1000,
  parameter int PULSE_LEN = 1,
  parameter int REP_DLY   = 50000,
  parameter int REP_PER   = 10000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_i,
  input  logic [1:0]      edge_mode,
  input  logic [N_CH-1:0] rep_en,
  output logic [N_CH-1:0] pulse_o,
  output logic [N_CH-1:0] level_o,
  output logic            any_pulse,
  output logic [N_CH-1:0] drop_o
);

  localparam int DEB_W = $clog2(DEB_CNT);
  localparam int T_MAX = (REP_DLY > REP_PER) ?
                         ((REP_DLY > PULSE_LEN) ? REP_DLY : PULSE_LEN) :
                         ((REP_PER > PULSE_LEN) ? REP_PER : PULSE_LEN);
  localparam int T_W   = $clog2(T_MAX + 1);

  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_CNT - 1);
  localparam logic [T_W-1:0]   PULSE_LAST = T_W'(PULSE_LEN - 1);
  localparam logic [T_W-1:0]   DLY_LAST   = T_W'(REP_DLY - 1);
  localparam logic [T_W-1:0]   PER_LAST   = T_W'(REP_PER - 1);
  localparam logic [T_W-1:0]   T_SAT      = T_W'(T_MAX);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    HOLD,
    REPEAT_WAIT
  } state_e;

  logic [N_CH-1:0] pulse_d;
  logic            any_pulse_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic             sync1_q, sync2_q;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             level_q, level_d, prev_q;
    state_e           state_q, state_d;
    logic [T_W-1:0]   tmr_q, tmr_d;
    logic             rep_q, rep_d;
    logic             drop_q, drop_d;
    logic             pulse_q;
    logic             evt, hold_ok;

    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
      deb_cnt_d = '0;
      level_d   = level_q;
      if (sync2_q != level_q) begin
        if (deb_cnt_q == DEB_LAST) level_d = ~level_q;
        else                       deb_cnt_d = deb_cnt_q + 1'b1;
      end

      unique case (edge_mode)
        2'b00:   evt = level_q & ~prev_q;
        2'b01:   evt = ~level_q & prev_q;
        2'b10:   evt = level_q ^ prev_q;
        default: evt = 1'b0;
      endcase
      hold_ok = level_q & rep_en[g] & (edge_mode != 2'b11);

      state_d = state_q;
      tmr_d   = (tmr_q == T_SAT) ? tmr_q : tmr_q + 1'b1;
      rep_d   = rep_q;
      drop_d  = drop_q;
      unique case (state_q)
        IDLE: begin
          if (evt) begin
            state_d = PULSE;
            tmr_d   = '0;
            rep_d   = 1'b0;
          end
        end
        PULSE: begin
          // Events during an active pulse are discarded, only flagged.
          if (evt) drop_d = 1'b1;
          if (tmr_q == PULSE_LAST) begin
            if (!hold_ok)   state_d = IDLE;
            else if (rep_q) state_d = REPEAT_WAIT;
            else            state_d = HOLD;
          end
        end
        HOLD, REPEAT_WAIT: begin
          if (evt) begin
            state_d = PULSE;
            tmr_d   = '0;
            rep_d   = 1'b0;
          end else if (!hold_ok) begin
            state_d = IDLE;
          end else if (tmr_q == ((state_q == HOLD) ? DLY_LAST : PER_LAST)) begin
            state_d = PULSE;
            tmr_d   = '0;
            rep_d   = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    assign pulse_d[g] = (state_d == PULSE);

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        deb_cnt_q <= '0;
        level_q   <= 1'b0;
        prev_q    <= 1'b0;
        state_q   <= IDLE;
        tmr_q     <= '0;
        rep_q     <= 1'b0;
        drop_q    <= 1'b0;
        pulse_q   <= 1'b0;
      end else begin
        sync1_q   <= btn_i[g];
        sync2_q   <= sync1_q;
        deb_cnt_q <= deb_cnt_d;
        level_q   <= level_d;
        prev_q    <= level_q;
        state_q   <= state_d;
        tmr_q     <= tmr_d;
        rep_q     <= rep_d;
        drop_q    <= drop_d;
        pulse_q   <= pulse_d[g];
      end
    end

    assign pulse_o[g] = pulse_q;
    assign level_o[g] = level_q;
    assign drop_o[g]  = drop_q;
  end

  // Built from next-state so any_pulse lines up with pulse_o in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) any_pulse_q <= 1'b0;
    else     any_pulse_q <= |pulse_d;
  end

  assign any_pulse = any_pulse_q;

endmodule

// File: tb/tb_multi_pulser.sv
// Self-checking bench for multi_pulser: three parameterisations, scoreboard of
// expected pulse start cycles compared against observed pulse starts.
module tb_multi_pulser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_a, btn_b, btn_c;
  logic [1:0] mode_a, mode_b, mode_c;
  logic [3:0] rep_a, rep_b, rep_c;
  logic [3:0] pulse_a, pulse_b, pulse_c;
  logic [3:0] level_a, level_b, level_c;
  logic [3:0] drop_a, drop_b, drop_c;
  logic       any_a, any_b, any_c;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int exp_q[$];
  int obs_q[$];
  int wid_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multi_pulser #(.N_CH(4), .DEB_CNT(4), .PULSE_LEN(1), .REP_DLY(20), .REP_PER(8)) dut_a (
    .clk(clk), .rst(rst), .btn_i(btn_a), .edge_mode(mode_a), .rep_en(rep_a),
    .pulse_o(pulse_a), .level_o(level_a), .any_pulse(any_a), .drop_o(drop_a));

  multi_pulser #(.N_CH(4), .DEB_CNT(2), .PULSE_LEN(3), .REP_DLY(20), .REP_PER(8)) dut_b (
    .clk(clk), .rst(rst), .btn_i(btn_b), .edge_mode(mode_b), .rep_en(rep_b),
    .pulse_o(pulse_b), .level_o(level_b), .any_pulse(any_b), .drop_o(drop_b));

  multi_pulser #(.N_CH(4), .DEB_CNT(4), .PULSE_LEN(2), .REP_DLY(20), .REP_PER(8)) dut_c (
    .clk(clk), .rst(rst), .btn_i(btn_c), .edge_mode(mode_c), .rep_en(rep_c),
    .pulse_o(pulse_c), .level_o(level_c), .any_pulse(any_c), .drop_o(drop_c));

  function automatic logic pbit(input int inst, input int ch);
    case (inst)
      0:       return pulse_a[ch];
      1:       return pulse_b[ch];
      default: return pulse_c[ch];
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    btn_a = '0; btn_b = '0; btn_c = '0;
    mode_a = 2'b00; mode_b = 2'b00; mode_c = 2'b00;
    rep_a = '0; rep_b = '0; rep_c = '0;
    tick(2);
    rst = 1'b0;
  endtask

  // Records start cycle and width of each pulse on one channel.
  task automatic watch(input int inst, input int ch, input int ncyc);
    logic b, prev;
    int   w;
    obs_q.delete();
    wid_q.delete();
    prev = pbit(inst, ch);
    w = 0;
    repeat (ncyc) begin
      @(negedge clk);
      b = pbit(inst, ch);
      if (b && !prev) begin
        obs_q.push_back(cyc);
        w = 1;
      end else if (b) begin
        w++;
      end
      if (!b && prev) wid_q.push_back(w);
      prev = b;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn_a = 4'hF; btn_b = 4'hF; btn_c = 4'hF;
    mode_a = 2'b00; mode_b = 2'b00; mode_c = 2'b00;
    rep_a = '0; rep_b = '0; rep_c = '0;
    tick(3);
    total++;
    if ({pulse_a, level_a, drop_a, any_a} !== 13'd0)
      $display("FAIL reset_a: got %b, expected 0", {pulse_a, level_a, drop_a, any_a});
    else passed++;
    total++;
    if ({pulse_b, level_b, drop_b, any_b, pulse_c, level_c, drop_c, any_c} !== 26'd0)
      $display("FAIL reset_bc: got %b, expected 0",
               {pulse_b, level_b, drop_b, any_b, pulse_c, level_c, drop_c, any_c});
    else passed++;
  endtask

  task automatic test_latency();
    int c0;
    do_reset();
    c0 = cyc;
    btn_a[0] = 1'b1;
    tick(5);
    total++;
    if (level_a[0] !== 1'b0) $display("FAIL lat_level_early: got %b, expected 0", level_a[0]);
    else passed++;
    tick(1);
    total++;
    if ({level_a[0], pulse_a[0]} !== 2'b10)
      $display("FAIL lat_level_edge6: got level/pulse %b, expected 10", {level_a[0], pulse_a[0]});
    else passed++;
    tick(1);
    total++;
    if ({pulse_a, any_a} !== 5'b0001_1)
      $display("FAIL lat_pulse_edge7: got pulse/any %b, expected 00011", {pulse_a, any_a});
    else passed++;
    tick(1);
    total++;
    if ({pulse_a[0], any_a} !== 2'b00)
      $display("FAIL lat_pulse_edge8: got pulse/any %b, expected 00", {pulse_a[0], any_a});
    else passed++;
    if (c0 < 0) $display("FAIL lat_cycle: got %0d", c0);
  endtask

  task automatic test_bounce();
    int c0, n_exp, e, o;
    do_reset();
    c0 = cyc;
    btn_a[1] = 1'b1; tick(1);
    btn_a[1] = 1'b0; tick(1);
    btn_a[1] = 1'b1; tick(1);
    btn_a[1] = 1'b0; tick(1);
    btn_a[1] = 1'b1;
    exp_q.push_back(c0 + 4 + 7);
    watch(0, 1, 25);
    n_exp = exp_q.size();
    total++;
    if (obs_q.size() != n_exp) $display("FAIL bounce_count: got %0d, expected %0d", obs_q.size(), n_exp);
    else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      total++;
      if (o !== e) $display("FAIL bounce_start: got cycle %0d, expected %0d", o, e);
      else passed++;
    end
  endtask

  task automatic test_modes();
    int c0, n_exp, e, o;
    do_reset();
    mode_a = 2'b01;
    c0 = cyc;
    btn_a[0] = 1'b1;
    exp_q.push_back(c0 + 15 + 7);
    fork
      watch(0, 0, 40);
      begin tick(15); btn_a[0] = 1'b0; end
    join
    n_exp = exp_q.size();
    total++;
    if (obs_q.size() != n_exp) $display("FAIL fall_count: got %0d, expected %0d", obs_q.size(), n_exp);
    else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      total++;
      if (o !== e) $display("FAIL fall_start: got cycle %0d, expected %0d", o, e);
      else passed++;
    end
    mode_a = 2'b11;
    btn_a[0] = 1'b1;
    watch(0, 0, 20);
    total++;
    if (obs_q.size() != 0) $display("FAIL mode11_count: got %0d, expected 0", obs_q.size());
    else passed++;
    total++;
    if (level_a[0] !== 1'b1) $display("FAIL mode11_level: got %b, expected 1", level_a[0]);
    else passed++;
  endtask

  task automatic test_both_drop();
    int c0, n_exp, e, o;
    do_reset();
    mode_b = 2'b10;
    c0 = cyc;
    btn_b[0] = 1'b1;
    exp_q.push_back(c0 + 5);
    exp_q.push_back(c0 + 25);
    fork
      watch(1, 0, 40);
      begin tick(20); btn_b[0] = 1'b0; end
    join
    n_exp = exp_q.size();
    total++;
    if (obs_q.size() != n_exp) $display("FAIL both_count: got %0d, expected %0d", obs_q.size(), n_exp);
    else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      total++;
      if (o !== e) $display("FAIL both_start: got cycle %0d, expected %0d", o, e);
      else passed++;
    end
    foreach (wid_q[i]) begin
      total++;
      if (wid_q[i] != 3) $display("FAIL both_width: got %0d, expected 3", wid_q[i]);
      else passed++;
    end
    total++;
    if (drop_b !== 4'b0000) $display("FAIL both_nodrop: got %b, expected 0000", drop_b);
    else passed++;

    do_reset();
    mode_b = 2'b10;
    c0 = cyc;
    btn_b[0] = 1'b1;
    exp_q.push_back(c0 + 5);
    fork
      watch(1, 0, 20);
      begin tick(2); btn_b[0] = 1'b0; end
    join
    n_exp = exp_q.size();
    total++;
    if (obs_q.size() != n_exp) $display("FAIL drop_count: got %0d, expected %0d", obs_q.size(), n_exp);
    else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      total++;
      if (o !== e) $display("FAIL drop_start: got cycle %0d, expected %0d", o, e);
      else passed++;
    end
    total++;
    if (drop_b !== 4'b0001) $display("FAIL drop_flag: got %b, expected 0001", drop_b);
    else passed++;
  endtask

  task automatic test_repeat();
    int c0, t0, n_exp, e, o;
    do_reset();
    rep_c[0] = 1'b1;
    c0 = cyc;
    t0 = c0 + 7;
    btn_c[0] = 1'b1;
    exp_q.push_back(t0);
    for (int k = 0; k < 5; k++) exp_q.push_back(t0 + 20 + 8 * k);
    fork
      watch(2, 0, 100);
      begin tick(57); btn_c[0] = 1'b0; end
    join
    n_exp = exp_q.size();
    total++;
    if (obs_q.size() != n_exp) $display("FAIL rep_count: got %0d, expected %0d", obs_q.size(), n_exp);
    else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      total++;
      if (o !== e) $display("FAIL rep_start: got cycle %0d, expected %0d", o, e);
      else passed++;
    end
    foreach (wid_q[i]) begin
      total++;
      if (wid_q[i] != 2) $display("FAIL rep_width: got %0d, expected 2", wid_q[i]);
      else passed++;
    end
  endtask

  task automatic test_rst_mid();
    int c0, r, n_exp, e, o;
    do_reset();
    c0 = cyc;
    btn_a[2] = 1'b1;
    tick(7);
    total++;
    if (pulse_a[2] !== 1'b1) $display("FAIL rstmid_pulse: got %b, expected 1 at cycle %0d", pulse_a[2], c0 + 7);
    else passed++;
    #1 rst = 1'b1;
    #1;
    total++;
    if ({pulse_a, level_a, any_a} !== 9'd0)
      $display("FAIL rstmid_clear: got %b, expected 0", {pulse_a, level_a, any_a});
    else passed++;
    tick(3);
    rst = 1'b0;
    r = cyc;
    exp_q.push_back(r + 7);
    watch(0, 2, 25);
    n_exp = exp_q.size();
    total++;
    if (obs_q.size() != n_exp) $display("FAIL rstmid_count: got %0d, expected %0d", obs_q.size(), n_exp);
    else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      total++;
      if (o !== e) $display("FAIL rstmid_start: got cycle %0d, expected %0d", o, e);
      else passed++;
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    btn_a = 4'hF;
    tick(7);
    total++;
    if ({pulse_a, any_a} !== 5'b1111_1)
      $display("FAIL simul_pulse: got pulse/any %b, expected 11111", {pulse_a, any_a});
    else passed++;
    tick(1);
    total++;
    if ({pulse_a, any_a} !== 5'b0000_0)
      $display("FAIL simul_after: got pulse/any %b, expected 00000", {pulse_a, any_a});
    else passed++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_bounce();
    test_modes();
    test_both_drop();
    test_repeat();
    test_rst_mid();
    test_simultaneous();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
    $fatal(1);
  end

endmodule

// File: doc/multi_pulser.md
MULTI_PULSER -- requirements
Module: multi_pulser

Interface
REQ-001 Parameter N_CH, 4, number of independent channels (1..16).
REQ-002 Parameter DEB_CNT, 1000, consecutive stable cycles required to accept a level change (2..65535).
REQ-003 Parameter PULSE_LEN, 1, output pulse width in clk cycles (1..255).
REQ-004 Parameter REP_DLY, 50000, held-high cycles before the first auto-repeat pulse (>= PULSE_LEN+1).
REQ-005 Parameter REP_PER, 10000, cycles between auto-repeat pulses (>= PULSE_LEN+1).
REQ-006 clk  input  1  single system clock; all state updates on its rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 btn_i  input  N_CH  raw asynchronous per-channel inputs (bouncing push-buttons).
REQ-009 edge_mode  input  2  00 rising, 01 falling, 10 both edges, 11 channel events disabled; shared by all channels.
REQ-010 rep_en  input  N_CH  per-channel auto-repeat enable.
REQ-011 pulse_o  output  N_CH  registered per-channel pulse, PULSE_LEN cycles wide.
REQ-012 level_o  output  N_CH  registered debounced level per channel.
REQ-013 any_pulse  output  1  registered OR of pulse_o.
REQ-014 drop_o  output  N_CH  sticky flag: an event was lost because that channel's pulse was still active; cleared only by rst.

Function
REQ-015 Each channel SHALL pass btn_i through a 2-flop synchroniser before any other logic.
REQ-016 The debounce counter SHALL increment each cycle the synchronised input differs from level_o, clear whenever they match, and toggle level_o (clearing the counter) on the cycle it would reach DEB_CNT.
REQ-017 A single bounce SHALL restart the count from zero; level_o SHALL NOT change until DEB_CNT consecutive differing cycles are seen.
REQ-018 An event is a level_o transition qualified by edge_mode; edge_mode is sampled on the cycle of the transition.
REQ-019 Latency: btn_i stable from edge 0 -> level_o changes at edge DEB_CNT+2 -> pulse_o first high at edge DEB_CNT+3.
REQ-020 Per-channel FSM states: IDLE, PULSE, HOLD, REPEAT_WAIT.
REQ-021 IDLE: an event -> PULSE; pulse_o high for exactly PULSE_LEN cycles.
REQ-022 PULSE end: if level_o=1 and rep_en=1 -> HOLD, else -> IDLE.
REQ-023 HOLD: counts cycles from the first-pulse start; at REP_DLY emits a pulse -> PULSE (repeat flavour) then REPEAT_WAIT.
REQ-024 REPEAT_WAIT: emits a pulse every REP_PER cycles from the previous pulse start while level_o=1 and rep_en=1.
REQ-025 In HOLD or REPEAT_WAIT, level_o=0 or rep_en=0 -> IDLE in the next cycle; a falling event in modes 01/10 then produces a pulse normally.
REQ-026 An event arriving while pulse_o is high SHALL be discarded, not queued, and SHALL set drop_o.
REQ-027 edge_mode=11 SHALL suppress new events and repeats; a pulse in progress SHALL complete its full PULSE_LEN.
REQ-028 Channels SHALL be fully independent; simultaneous events on several channels SHALL each pulse in the same cycle.
REQ-029 Counters SHALL be sized by $clog2 of their limits and SHALL NOT wrap; they saturate or clear per the rules above.

Reset
REQ-030 rst SHALL immediately force pulse_o=0, level_o=0, any_pulse=0, drop_o=0, all counters to 0 and every FSM to IDLE, including mid-pulse.
REQ-031 After rst releases, an input already held high SHALL be treated as a rising change and produce one pulse after full debounce (modes 00 and 10).

Verification
REQ-032 DEB_CNT=4, PULSE_LEN=1, mode 00: btn_i[0] 0->1 clean at edge 0 -> level_o[0] rises at edge 6, pulse_o[0] high only at edge 7.
REQ-033 DEB_CNT=4: btn_i[1] toggles 1,0,1,0 at 1-cycle intervals then holds 1 -> exactly one pulse, 7 cycles after the final rise.
REQ-034 Mode 10, PULSE_LEN=3: press, then release -> two 3-cycle pulses; release debounced within the first pulse -> drop_o set, only one pulse.
REQ-035 rep_en=1, REP_DLY=20, REP_PER=8, PULSE_LEN=2: hold 60 cycles -> pulses start at t0, t0+20, t0+28, t0+36, t0+44, t0+52 (t0 = first pulse); release stops repeats.
REQ-036 rst asserted during pulse_o high -> pulse_o low within the same cycle, no resumption; btn_i held high through release -> one pulse DEB_CNT+3 cycles after rst falls.
REQ-037 All N_CH=4 channels pressed on the same edge -> pulse_o=4'b1111 and any_pulse=1 in one cycle.
